// File: rtl/recip_pkg.sv
// Shared types and elaboration helpers for the reciprocal datapath.
// pg_t carries prefix P/G vectors with bit -1 stored at index 0.
package recip_pkg;

    localparam int PP_WIDTH = 16;

    typedef struct packed {
        logic [PP_WIDTH:0] p;
        logic [PP_WIDTH:0] g;
    } pg_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int pp_latency(input int w, input int re);
        int lv;
        lv = clog2(w);
        return 2 + (lv + re - 1) / re;
    endfunction

endpackage

// File: rtl/pp_adder_pipe_level.sv
// Prefix-cell primitives and one combinational Kogge-Stone level.
// Node n holds bit n-1; node 0 is the carry-in (bit -1).
module pp_black_cell (
    input  logic i_gh,
    input  logic i_ph,
    input  logic i_gl,
    input  logic i_pl,
    output logic o_g,
    output logic o_p
);
    assign o_g = i_gh | (i_ph & i_gl);
    assign o_p = i_ph & i_pl;
endmodule

module pp_gray_cell (
    input  logic i_gh,
    input  logic i_ph,
    input  logic i_gl,
    output logic o_g
);
    assign o_g = i_gh | (i_ph & i_gl);
endmodule

module pp_level
    import recip_pkg::*;
#(
    parameter int WIDTH = PP_WIDTH,
    parameter int SPAN  = 1
) (
    input  pg_t i_pg,
    output pg_t o_pg
);
    logic [WIDTH:0] w_p;
    logic [WIDTH:0] w_g;

    for (genvar n = 0; n <= WIDTH; n++) begin : g_node
        if (n < SPAN) begin : g_pass
            assign w_p[n] = i_pg.p[n];
            assign w_g[n] = i_pg.g[n];
        end else if (n - SPAN < SPAN) begin : g_gray
            // Lower group already reaches bit -1, whose P is 0.
            pp_gray_cell u_gray (
                .i_gh (i_pg.g[n]),
                .i_ph (i_pg.p[n]),
                .i_gl (i_pg.g[n-SPAN]),
                .o_g  (w_g[n])
            );
            assign w_p[n] = 1'b0;
        end else begin : g_black
            pp_black_cell u_black (
                .i_gh (i_pg.g[n]),
                .i_ph (i_pg.p[n]),
                .i_gl (i_pg.g[n-SPAN]),
                .i_pl (i_pg.p[n-SPAN]),
                .o_g  (w_g[n]),
                .o_p  (w_p[n])
            );
        end
    end

    assign o_pg = '{p: w_p, g: w_g};

endmodule

// File: rtl/pp_adder_pipe.sv
// Pipelined Kogge-Stone adder, registers every REG_EVERY prefix levels.
// Define PP_ADDER_OVF_EN to add the registered signed-overflow port ovf.
module pp_adder_pipe
    import recip_pkg::*;
#(
    parameter int WIDTH     = PP_WIDTH,
    parameter int REG_EVERY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef PP_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int NLVL = clog2(WIDTH);
    localparam int NREG = (NLVL + REG_EVERY - 1) / REG_EVERY;

    logic             w_adv;
    pg_t              r_s0;
    logic [WIDTH-1:0] r_s0_x;
    logic             r_s0_v;
    pg_t              w_lin  [NLVL];
    pg_t              w_lout [NLVL];
    pg_t              w_rin  [NREG];
    pg_t              r_pg   [NREG];
    logic [WIDTH-1:0] r_x    [NREG];
    logic             r_v    [NREG];
    pg_t              w_fin;
    logic             w_co;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_out_v;
    logic             w_unused_p;

    assign w_adv    = out_ready | ~r_out_v;
    assign in_ready = w_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0   <= '0;
            r_s0_x <= '0;
            r_s0_v <= 1'b0;
        end else if (w_adv) begin
            r_s0   <= '{p: {a ^ b, 1'b0}, g: {a & b, cin}};
            r_s0_x <= a ^ b;
            r_s0_v <= in_valid;
        end
    end

    for (genvar k = 0; k < NLVL; k++) begin : g_lvl
        if (k == 0) begin : g_from_s0
            assign w_lin[k] = r_s0;
        end else if (k % REG_EVERY == 0) begin : g_from_reg
            assign w_lin[k] = r_pg[k/REG_EVERY-1];
        end else begin : g_from_lvl
            assign w_lin[k] = w_lout[k-1];
        end
        pp_level #(
            .WIDTH (WIDTH),
            .SPAN  (1 << k)
        ) u_lvl (
            .i_pg (w_lin[k]),
            .o_pg (w_lout[k])
        );
    end

    for (genvar r = 0; r < NREG; r++) begin : g_rin
        localparam int LAST = (r * REG_EVERY + REG_EVERY - 1 < NLVL)
                            ? r * REG_EVERY + REG_EVERY - 1 : NLVL - 1;
        assign w_rin[r] = w_lout[LAST];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                r_pg[r] <= '0;
                r_x[r]  <= '0;
                r_v[r]  <= 1'b0;
            end
        end else if (w_adv) begin
            r_x[0] <= r_s0_x;
            r_v[0] <= r_s0_v;
            for (int r = 1; r < NREG; r++) begin
                r_x[r] <= r_x[r-1];
                r_v[r] <= r_v[r-1];
            end
            for (int r = 0; r < NREG; r++) r_pg[r] <= w_rin[r];
        end
    end

    // The top node spans bits W-1..0 only; fold in bit -1 here.
    assign w_fin      = r_pg[NREG-1];
    assign w_co       = w_fin.g[WIDTH] | (w_fin.p[WIDTH] & w_fin.g[0]);
    assign w_unused_p = ^w_fin.p[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_out_v <= 1'b0;
        end else if (w_adv) begin
            r_sum   <= w_fin.g[WIDTH-1:0] ^ r_x[NREG-1];
            r_cout  <= w_co;
            r_out_v <= r_v[NREG-1];
        end
    end

`ifdef PP_ADDER_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_ovf <= w_fin.g[WIDTH-1] ^ w_co;
        end
    end

    assign ovf = r_ovf;
`endif

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign out_valid = r_out_v;

endmodule

// File: tb/tb_pp_adder_pipe.sv
// Bench for pp_adder_pipe: REG_EVERY=1 (L=6) and REG_EVERY=2 (L=4) side by side.
`timescale 1ns/1ps
module tb_pp_adder_pipe;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_ready;

    logic        in_ready1, out_valid1, cout1, ovf1;
    logic [15:0] sum1;
    logic        in_ready2, out_valid2, cout2, ovf2;
    logic [15:0] sum2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exact_lat;

    exp_t q0[$];
    exp_t q1[$];
    int   e0[$];
    int   e1[$];
    logic hold_p [2];
    logic [15:0] hs [2];
    logic hc [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pp_adder_pipe #(.WIDTH(16), .REG_EVERY(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .sum       (sum1),
`ifdef PP_ADDER_OVF_EN
        .ovf       (ovf1),
`endif
        .cout      (cout1)
    );

    pp_adder_pipe #(.WIDTH(16), .REG_EVERY(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .sum       (sum2),
`ifdef PP_ADDER_OVF_EN
        .ovf       (ovf2),
`endif
        .cout      (cout2)
    );

`ifndef PP_ADDER_OVF_EN
    assign ovf1 = 1'b0;
    assign ovf2 = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] ia, input logic [15:0] ib,
                                   input logic ic, input int t);
        exp_t e;
        logic [16:0] tot;
        int s;
        tot = {1'b0, ia} + {1'b0, ib} + {16'd0, ic};
        s = int'($signed(ia)) + int'($signed(ib)) + int'(ic);
        e.s = tot[15:0];
        e.c = tot[16];
        e.o = (s > 32767) || (s < -32768);
        e.acc = t;
        return e;
    endfunction

    // Scoreboard: pop on emit, push on accept, check hold under stall.
    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            hold_p[0] = 1'b0;
            hold_p[1] = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                logic ov, ir, co, of;
                logic [15:0] sm;
                int lat;
                exp_t e;
                ov  = (d == 0) ? out_valid1 : out_valid2;
                ir  = (d == 0) ? in_ready1 : in_ready2;
                co  = (d == 0) ? cout1 : cout2;
                of  = (d == 0) ? ovf1 : ovf2;
                sm  = (d == 0) ? sum1 : sum2;
                lat = (d == 0) ? 6 : 4;
                if (hold_p[d]) begin
                    chk($sformatf("dut%0d_hold_valid", d), ov, 1);
                    chk($sformatf("dut%0d_hold_sum", d), sm, hs[d]);
                    chk($sformatf("dut%0d_hold_cout", d), co, hc[d]);
                end
                if (ov && !out_ready)
                    chk($sformatf("dut%0d_stall_in_ready", d), ir, 0);
                if (ov && out_ready) begin
                    if (((d == 0) ? q0.size() : q1.size()) == 0) begin
                        chk($sformatf("dut%0d_unexpected_out", d), ov, 0);
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("dut%0d_sum", d), sm, e.s);
                        chk($sformatf("dut%0d_cout", d), co, e.c);
`ifdef PP_ADDER_OVF_EN
                        chk($sformatf("dut%0d_ovf", d), of, e.o);
`endif
                        if (exact_lat != 0)
                            chk($sformatf("dut%0d_latency", d), cyc - e.acc, lat);
                    end
                    if (d == 0) e0.push_back(cyc);
                    else e1.push_back(cyc);
                end
                if (in_valid && ir) begin
                    if (d == 0) q0.push_back(model(a, b, cin, cyc));
                    else q1.push_back(model(a, b, cin, cyc));
                end
                hold_p[d] = ov && !out_ready;
                hs[d] = sm;
                hc[d] = co;
            end
        end
    end

    task automatic send(input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic);
        int n;
        n = 0;
        in_valid = 1'b1;
        a = ia;
        b = ib;
        cin = ic;
        @(negedge clk);
        while (!in_ready1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("send_timeout", in_ready1, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n0, n1, t0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        out_ready = 1'b1;
        exact_lat = 1;
        #1;
        chk("reset_out_valid", out_valid1, 0);
        chk("reset_sum", sum1, 0);
        chk("reset_cout", cout1, 0);
        chk("reset_out_valid2", out_valid2, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_in_ready", in_ready1, 1);
        chk("post_reset_in_ready2", in_ready2, 1);

        n0 = e0.size();
        n1 = e1.size();
        t0 = cyc;
        send(16'hFFFF, 16'h0001, 1'b0);
        idle(10);
        chk("wrap_count", e0.size() - n0, 1);
        chk("wrap_cycle", e0[n0], t0 + 6);
        chk("wrap_cycle2", e1[n1], t0 + 4);

        send(16'h1234, 16'h0000, 1'b1);
        idle(2);
        send(16'h7FFF, 16'h0001, 1'b0);
        send(16'h8000, 16'h8000, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b1);
        idle(10);

        n0 = e0.size();
        t0 = cyc;
        for (int i = 0; i < 8; i++)
            send(16'($urandom), 16'($urandom), 1'($urandom));
        idle(12);
        chk("stream_count", e0.size() - n0, 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("stream_cycle%0d", i), e0[n0 + i], t0 + 6 + i);

        exact_lat = 0;
        n0 = e0.size();
        fork
            begin
                for (int i = 0; i < 12; i++)
                    send(16'($urandom), 16'($urandom), 1'($urandom));
                in_valid = 1'b0;
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready", in_ready1, 0);
                    chk("bp_in_ready2", in_ready2, 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(20);
        chk("bp_count", e0.size() - n0, 12);
        chk("bp_drain", q0.size(), 0);
        chk("bp_drain2", q1.size(), 0);

        exact_lat = 1;
        for (int i = 0; i < 6; i++)
            send(16'($urandom), 16'($urandom), 1'($urandom));
        in_valid = 1'b0;
        #2;
        chk("pre_reset_valid", out_valid1, 1);
        n0 = e0.size();
        n1 = e1.size();
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", out_valid1, 0);
        chk("midreset_sum", sum1, 0);
        chk("midreset_out_valid2", out_valid2, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(12);
        chk("midreset_no_stale", e0.size() - n0, 0);
        chk("midreset_no_stale2", e1.size() - n1, 0);

        send(16'hABCD, 16'h5432, 1'b1);
        idle(10);
        chk("after_reset_count", e0.size() - n0, 1);
        chk("after_reset_count2", e1.size() - n1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
